// File: rtl/traffic_phase_controller.sv
// ---------------------------------------------------------------------------------------------
// traffic_phase_controller
//
// Adaptive two-road intersection phase FSM. Advances through
//   RED_TO_NS -> NS_GREEN -> NS_YELLOW -> RED_TO_EW -> EW_GREEN -> EW_YELLOW -> RED_TO_NS
// counting `tick` pulses from the upstream timer stage. A green phase is held past its minimum
// while the active road still has demand and the cross road has none, and is cut off at its
// maximum. Every phase change produces a one-cycle `timer_restart` pulse back to the timer.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous, active-high reset
//   tick          in   one-cycle timing-unit pulse (each high cycle counts as one tick)
//   ns_req        in   North-South demand, synchronous to clk
//   ew_req        in   East-West demand, synchronous to clk
//   ns_light      out  NS lamps {red,yellow,green}, one-hot
//   ew_light      out  EW lamps {red,yellow,green}, one-hot
//   phase         out  current state encoding (0..5)
//   elapsed       out  ticks elapsed in the current phase
//   timer_restart out  registered pulse, high the cycle after any phase change
// ---------------------------------------------------------------------------------------------
module traffic_phase_controller #(
    parameter int unsigned GREEN_MIN = 8,   // minimum green, in ticks (>= 1)
    parameter int unsigned GREEN_MAX = 20,  // maximum green, in ticks (>= GREEN_MIN)
    parameter int unsigned YELLOW_T  = 3,   // yellow duration, in ticks (>= 1)
    parameter int unsigned ALLRED_T  = 1,   // all-red clearance, in ticks (>= 1)
    parameter int unsigned CNT_W     = 5    // elapsed-counter width, must hold GREEN_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ns_req,
    input  logic             ew_req,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] elapsed,
    output logic             timer_restart
);

    // -----------------------------------------------------------------------------------------
    // Encodings
    // -----------------------------------------------------------------------------------------
    typedef enum logic [2:0] {
        StNsGreen  = 3'd0,
        StNsYellow = 3'd1,
        StRedToEw  = 3'd2,
        StEwGreen  = 3'd3,
        StEwYellow = 3'd4,
        StRedToNs  = 3'd5
    } phase_e;

    localparam logic [2:0] LampRed    = 3'b100;
    localparam logic [2:0] LampYellow = 3'b010;
    localparam logic [2:0] LampGreen  = 3'b001;

    localparam logic [CNT_W-1:0] GreenMinC = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] GreenMaxC = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] YellowC   = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] AllRedC   = CNT_W'(ALLRED_T);

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    phase_e           state_q, state_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic             timer_restart_q, timer_restart_d;

    // Next-state helpers
    logic [CNT_W-1:0] cnt_next;     // n = elapsed + 1, the tick count if this tick is taken
    logic             own_req;      // demand on the road currently holding green
    logic             cross_req;    // demand on the road currently held at red
    logic             green_forced;
    logic             green_early;
    logic             exit_now;     // current phase is complete on this tick
    logic             state_illegal;
    phase_e           state_succ;   // successor in the fixed phase ring

    // Elapsed is bounded by GREEN_MAX-1 by the exit rules, so n never overflows CNT_W.
    assign cnt_next = elapsed_q + CNT_W'(1);

    // -----------------------------------------------------------------------------------------
    // Process 1: state register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StRedToNs;
            elapsed_q       <= '0;
            timer_restart_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            elapsed_q       <= elapsed_d;
            timer_restart_q <= timer_restart_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Process 2: next-state logic
    // -----------------------------------------------------------------------------------------

    // Own/cross demand are swapped depending on which road holds green. Outside the green
    // phases the values are unused.
    always_comb begin
        own_req   = ns_req;
        cross_req = ew_req;
        if (state_q == StEwGreen) begin
            own_req   = ew_req;
            cross_req = ns_req;
        end
    end

    // Green ends at the hard maximum, or once the minimum is met and there is either a
    // competing request or nobody left to serve on the active road.
    assign green_forced = (cnt_next == GreenMaxC);
    assign green_early  = (cnt_next >= GreenMinC) && (cross_req || !own_req);

    always_comb begin
        exit_now      = 1'b0;
        state_illegal = 1'b0;
        state_succ    = StRedToNs;
        case (state_q)
            StNsGreen: begin
                exit_now   = green_forced || green_early;
                state_succ = StNsYellow;
            end
            StNsYellow: begin
                exit_now   = (cnt_next == YellowC);
                state_succ = StRedToEw;
            end
            StRedToEw: begin
                exit_now   = (cnt_next == AllRedC);
                state_succ = StEwGreen;
            end
            StEwGreen: begin
                exit_now   = green_forced || green_early;
                state_succ = StEwYellow;
            end
            StEwYellow: begin
                exit_now   = (cnt_next == YellowC);
                state_succ = StRedToNs;
            end
            StRedToNs: begin
                exit_now   = (cnt_next == AllRedC);
                state_succ = StNsGreen;
            end
            default: begin
                state_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        if (state_illegal) begin
            // Recover to a safe all-red state without waiting for a tick.
            state_d   = StRedToNs;
            elapsed_d = '0;
        end else if (tick) begin
            if (exit_now) begin
                state_d   = state_succ;
                elapsed_d = '0;
            end else begin
                elapsed_d = cnt_next;
            end
        end
        // Registered, so the pulse lands in the first cycle of the new phase.
        timer_restart_d = (state_d != state_q);
    end

    // -----------------------------------------------------------------------------------------
    // Process 3: output decode (Moore, straight from the state register)
    // -----------------------------------------------------------------------------------------
    always_comb begin
        ns_light = LampRed;
        ew_light = LampRed;
        case (state_q)
            StNsGreen:  ns_light = LampGreen;
            StNsYellow: ns_light = LampYellow;
            StEwGreen:  ew_light = LampGreen;
            StEwYellow: ew_light = LampYellow;
            default:    ;  // all-red and illegal codes keep both roads at red
        endcase
    end

    assign phase         = state_q;
    assign elapsed       = elapsed_q;
    assign timer_restart = timer_restart_q;

    // -----------------------------------------------------------------------------------------
    // Safety properties
    // -----------------------------------------------------------------------------------------
    a_no_conflict: assert property (@(posedge clk) disable iff (rst)
        (ns_light == LampRed) || (ew_light == LampRed));

    a_elapsed_bound: assert property (@(posedge clk) disable iff (rst)
        elapsed_q < GreenMaxC);

endmodule

// File: tb/tb_traffic_phase_controller.sv
module tb_traffic_phase_controller;

    localparam int GMIN = 8;
    localparam int GMAX = 20;
    localparam int YT   = 3;
    localparam int ART  = 1;
    localparam int CW   = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic          ns_req;
    logic          ew_req;
    logic [2:0]    ns_light;
    logic [2:0]    ew_light;
    logic [2:0]    phase;
    logic [CW-1:0] elapsed;
    logic          timer_restart;

    always #5 clk = ~clk;

    traffic_phase_controller #(
        .GREEN_MIN (GMIN),
        .GREEN_MAX (GMAX),
        .YELLOW_T  (YT),
        .ALLRED_T  (ART),
        .CNT_W     (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .ns_req        (ns_req),
        .ew_req        (ew_req),
        .ns_light      (ns_light),
        .ew_light      (ew_light),
        .phase         (phase),
        .elapsed       (elapsed),
        .timer_restart (timer_restart)
    );

    typedef struct packed {
        logic [2:0]    ph;
        logic [CW-1:0] el;
        logic          tr;
        logic [2:0]    nl;
        logic [2:0]    ewl;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    int m_phase;
    int m_elapsed;
    bit m_tr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Lamp table: {ns, ew}, lamps are {red,yellow,green}
    function automatic logic [5:0] lamps(input int p);
        case (p)
            0:       return {3'b001, 3'b100};
            1:       return {3'b010, 3'b100};
            3:       return {3'b100, 3'b001};
            4:       return {3'b100, 3'b010};
            default: return {3'b100, 3'b100};
        endcase
    endfunction

    task automatic model_reset();
        m_phase   = 5;
        m_elapsed = 0;
        m_tr      = 1'b0;
        sb_q.delete();
    endtask

    // One clock: drive inputs, predict, push expectation, sample after the edge and compare.
    task automatic step(input bit t, input bit ns, input bit ew);
        int         n;
        int         np;
        int         ne;
        bit         ex;
        exp_t       e;
        exp_t       g;
        logic [5:0] lp;
        @(negedge clk);
        tick   = t;
        ns_req = ns;
        ew_req = ew;
        np = m_phase;
        ne = m_elapsed;
        ex = 1'b0;
        if (t) begin
            n = m_elapsed + 1;
            case (m_phase)
                0:       ex = (n == GMAX) || ((n >= GMIN) && (ew || !ns));
                3:       ex = (n == GMAX) || ((n >= GMIN) && (ns || !ew));
                1, 4:    ex = (n == YT);
                default: ex = (n == ART);
            endcase
            if (ex) begin
                np = (m_phase + 1) % 6;
                ne = 0;
            end else begin
                ne = n;
            end
        end
        m_tr      = (np != m_phase);
        m_phase   = np;
        m_elapsed = ne;
        lp    = lamps(np);
        e.ph  = 3'(np);
        e.el  = CW'(ne);
        e.tr  = m_tr;
        e.nl  = lp[5:3];
        e.ewl = lp[2:0];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            g = sb_q.pop_front();
            check("phase", 32'(phase), 32'(g.ph));
            check("elapsed", 32'(elapsed), 32'(g.el));
            check("timer_restart", 32'(timer_restart), 32'(g.tr));
            check("ns_light", 32'(ns_light), 32'(g.nl));
            check("ew_light", 32'(ew_light), 32'(g.ewl));
            check("no_conflict", 32'((ns_light != 3'b100) && (ew_light != 3'b100)), 32'd0);
        end
    endtask

    // Tick (with an idle cycle before each tick) until the model leaves phase p.
    task automatic run_phase(input int p, input bit ns, input bit ew, output int ticks);
        ticks = 0;
        for (int i = 0; i < 200 && m_phase == p; i++) begin
            step(1'b0, ns, ew);
            step(1'b1, ns, ew);
            ticks++;
        end
        check("run_phase_bound", 32'(m_phase != p), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_phase"}, 32'(phase), 32'd5);
        check({tag, "_elapsed"}, 32'(elapsed), 32'd0);
        check({tag, "_restart"}, 32'(timer_restart), 32'd0);
        check({tag, "_ns_light"}, 32'(ns_light), 32'h4);
        check({tag, "_ew_light"}, 32'(ew_light), 32'h4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst    = 1'b1;
        tick   = 1'b0;
        ns_req = 1'b0;
        ew_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Idle cycle after reset release: no restart pulse, state holds.
        step(1'b0, 1'b1, 1'b0);
        check("post_reset_restart", 32'(timer_restart), 32'd0);

        // NS demand only: green runs to its maximum.
        step(1'b1, 1'b1, 1'b0);
        check("first_tick_phase", 32'(phase), 32'd0);
        check("first_tick_restart", 32'(timer_restart), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        check("restart_one_cycle", 32'(timer_restart), 32'd0);
        run_phase(0, 1'b1, 1'b0, t);
        check("ns_green_max_ticks", 32'(t), 32'(GMAX));
        run_phase(1, 1'b1, 1'b0, t);
        check("ns_yellow_ticks", 32'(t), 32'(YT));
        run_phase(2, 1'b1, 1'b0, t);
        check("red_to_ew_ticks", 32'(t), 32'(ART));
        check("reach_ew_green", 32'(phase), 32'd3);

        // No demand anywhere: EW green lasts the minimum; full ring back to NS green.
        run_phase(3, 1'b0, 1'b0, t);
        check("ew_green_nodemand_ticks", 32'(t), 32'(GMIN));
        run_phase(4, 1'b0, 1'b0, t);
        run_phase(5, 1'b0, 1'b0, t);
        check("ring_back_ns_green", 32'(phase), 32'd0);

        // Cross demand from the start: NS green exits on the minimum.
        run_phase(0, 1'b0, 1'b1, t);
        check("ns_green_cross_ticks", 32'(t), 32'(GMIN));
        run_phase(1, 1'b0, 1'b1, t);
        run_phase(2, 1'b0, 1'b1, t);
        run_phase(3, 1'b1, 1'b0, t);
        run_phase(4, 1'b1, 1'b0, t);
        run_phase(5, 1'b1, 1'b0, t);

        // Cross demand arriving late: exit on tick 13.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
        check("late_cross_elapsed", 32'(elapsed), 32'd12);
        check("late_cross_still_green", 32'(phase), 32'd0);
        step(1'b1, 1'b1, 1'b1);
        check("late_cross_exit", 32'(phase), 32'd1);

        // tick held high for 4 cycles from NS yellow.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("held_tick_yellow_exit", 32'(phase), 32'd2);
        step(1'b1, 1'b1, 1'b1);
        check("held_tick_allred_exit", 32'(phase), 32'd3);
        check("held_tick_elapsed", 32'(elapsed), 32'd0);

        // Asynchronous reset in EW yellow with elapsed = 2.
        run_phase(3, 1'b1, 1'b0, t);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("pre_reset_phase", 32'(phase), 32'd4);
        check("pre_reset_elapsed", 32'(elapsed), 32'd2);
        tick = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check_reset_values("after_async_reset");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
Adaptive two-road intersection phase FSM. It sits directly downstream of the tick/timer stage and consumes its one-cycle `tick` (phase-elapsed) pulses. It issues `timer_restart` back to that stage on every phase change. It drives North-South and East-West lamp outputs, extending green while the active road has demand and the cross road has none, bounded by min/max limits.

Parameters:
GREEN_MIN, 8, minimum green duration in ticks (>=1)
GREEN_MAX, 20, maximum green duration in ticks (>=GREEN_MIN)
YELLOW_T, 3, yellow duration in ticks (>=1)
ALLRED_T, 1, all-red clearance duration in ticks (>=1)
CNT_W, 5, elapsed-counter width; must hold GREEN_MAX

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
tick  input  1  one-cycle pulse, one per timing unit, from upstream timer
ns_req  input  1  NS vehicle demand, already synchronous to clk
ew_req  input  1  EW vehicle demand, already synchronous to clk
ns_light  output  3  NS lamps {red,yellow,green}, one-hot
ew_light  output  3  EW lamps {red,yellow,green}, one-hot
phase  output  3  current state encoding
elapsed  output  CNT_W  ticks elapsed in current phase
timer_restart  output  1  one-cycle pulse on the cycle after any phase change

Behaviour:
- Clock/reset: one clock, `clk`. Reset `rst` is asynchronous and active-high; all registers clear immediately on assertion.
- States: 0 NS_GREEN, 1 NS_YELLOW, 2 RED_TO_EW, 3 EW_GREEN, 4 EW_YELLOW, 5 RED_TO_NS. Codes 6 and 7 are illegal; from an illegal code, go to RED_TO_NS on the next clk.
- Reset values:
  - phase=5 (RED_TO_NS), elapsed=0, timer_restart=0.
  - ns_light=3'b100, ew_light=3'b100.
- Lamp outputs are a pure decode of the state register (Moore, zero added latency):
  - NS_GREEN: NS green, EW red.
  - NS_YELLOW: NS yellow, EW red.
  - EW_GREEN: EW green, NS red.
  - EW_YELLOW: EW yellow, NS red.
  - All-red states: both red.
- Both roads must never be non-red in the same cycle.
- Counting:
  - On a clk edge with tick=1, define n = elapsed+1.
  - If the phase exits (rules below), the state advances and elapsed loads 0. Otherwise elapsed loads n.
  - With tick=0, state and elapsed hold.
- Exit rules (evaluated only on tick cycles):
  - YELLOW: exit when n==YELLOW_T.
  - All-red: exit when n==ALLRED_T.
  - GREEN exits when either holds:
    - n==GREEN_MAX (forced), or
    - n>=GREEN_MIN and (cross_req==1 or own_req==0).
  - own_req/cross_req are ns_req/ew_req for NS_GREEN, swapped for EW_GREEN.
  - Requests are sampled on the tick cycle only.
- Sequence: 5→0→1→2→3→4→5. No phase is skipped, even when neither road has demand; green then lasts GREEN_MIN.
- timer_restart:
  - Registered; equals 1 exactly in the cycle following each state change, 0 otherwise.
  - It is not asserted on reset exit.
- tick in the cycle right after a transition: counts toward the new phase, regardless of timer_restart.
- tick held high for multiple cycles: each cycle counts as one tick (no edge detection).
- Reset mid-phase: immediate return to reset values; any pending timer_restart is cleared.
- elapsed never exceeds GREEN_MAX-1 and never wraps.

Test Plan:
- Reset, then 1 tick, ns_req=1, ew_req=0 held → phase 5→0 after tick 1, timer_restart high one cycle; NS green for exactly 20 ticks; then NS_YELLOW for 3 ticks; RED_TO_EW 1 tick; then EW_GREEN.
- In NS_GREEN, ew_req=1 from start → exit to NS_YELLOW on the 8th tick, elapsed sequence 0..7 then 0.
- In NS_GREEN, ns_req=1, ew_req rises just before the 13th tick → NS_YELLOW entered on tick 13 (n=13≥8); elapsed was 12.
- In EW_GREEN, ew_req=0, ns_req=0 → exit on tick 8 (no own demand); full cycle 5,0,1,2,3,4,5 observed; no cycle has both lamps non-red.
- Assert rst asynchronously mid-EW_YELLOW with elapsed=2 → within the same cycle phase=5, elapsed=0, both lamps 3'b100, timer_restart=0.
- tick held high 4 consecutive cycles in NS_YELLOW (YELLOW_T=3) → exits on 3rd cycle; 4th cycle counts as elapsed=1 in RED_TO_EW, which then exits (ALLRED_T=1) to EW_GREEN.
